// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control pipeline: control-word widths,
// bit positions inside memctrl/muxctrl, forwarding-select encodings and
// the all-zero NOOP control word loaded by reset and by bubbles.
package mips_pkg;

    // Default widths of the control word fields and register addresses
    localparam int DEF_REG_AW = 5;
    localparam int DEF_MUXW   = 7;
    localparam int DEF_MEMW   = 3;
    localparam int DEF_ALUW   = 5;

    // memctrl bit positions
    localparam int REGWR = 0;
    localparam int MEMWR = 1;
    localparam int MEMRD = 2;

    // muxctrl bit positions
    localparam int ALUSRC   = 0;
    localparam int MEMTOREG = 1;
    localparam int BUBBLE   = 4;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // NOOP control word: every field cleared
    localparam logic [DEF_MUXW-1:0]   NOOP_MUXCTRL = {DEF_MUXW{1'b0}};
    localparam logic [DEF_MEMW-1:0]   NOOP_MEMCTRL = {DEF_MEMW{1'b0}};
    localparam logic [DEF_ALUW-1:0]   NOOP_ALUCTRL = {DEF_ALUW{1'b0}};
    localparam logic [DEF_REG_AW-1:0] NOOP_REG     = {DEF_REG_AW{1'b0}};

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection and EX operand forwarding selects.
// Build option HAZ_FWD_EN:
//   defined   - forwarding from MEM/WB, only load-use dependencies stall.
//   undefined - no forwarding (selects fixed at regfile); any dependency on
//               a register written by the instructions in EX or MEM stalls.
// A flush from the ID stage always wins: it produces a bubble and no stall.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_flush,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_uses_rt,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_dst,
    output logic              stall,
    output logic              bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // True when dst names a real register (not r0) equal to src
    function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        reg_hit = (dst != {REG_AW{1'b0}}) && (dst == src);
    endfunction

    logic hazard_s;
    logic id_dep_ex_s;
    logic id_dep_mem_s;

    // Does the ID instruction read a register produced in EX / in MEM
    always_comb begin
        id_dep_ex_s  = reg_hit(id_rs, ex_dst)  || (id_uses_rt && reg_hit(id_rt, ex_dst));
        id_dep_mem_s = reg_hit(id_rs, mem_dst) || (id_uses_rt && reg_hit(id_rt, mem_dst));
    end

`ifdef HAZ_FWD_EN

    logic unused_ok_s;
    assign unused_ok_s = ex_regwrite ^ mem_regwrite ^ (^mem_dst) ^ id_dep_mem_s;

    // Only a load in EX feeding the ID instruction cannot be forwarded in time
    always_comb begin
        if (ex_memread && id_dep_ex_s) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Operand A source: the youngest producer (MEM) wins over WB
    always_comb begin
        if (mem_regwrite && reg_hit(ex_rs, mem_dst)) begin
            fwd_a = FWD_MEM;
        end else if (wb_regwrite && reg_hit(ex_rs, wb_dst)) begin
            fwd_a = FWD_WB;
        end else begin
            fwd_a = FWD_RF;
        end
    end

    // Operand B source: same priority, but only if rt is really an operand
    always_comb begin
        if (!ex_uses_rt) begin
            fwd_b = FWD_RF;
        end else if (mem_regwrite && reg_hit(ex_rt, mem_dst)) begin
            fwd_b = FWD_MEM;
        end else if (wb_regwrite && reg_hit(ex_rt, wb_dst)) begin
            fwd_b = FWD_WB;
        end else begin
            fwd_b = FWD_RF;
        end
    end

`else

    logic unused_ok_s;
    assign unused_ok_s = ex_memread ^ (^ex_rs) ^ (^ex_rt) ^ ex_uses_rt ^
                         wb_regwrite ^ (^wb_dst);

    // Without forwarding, wait until the producer has reached WB; the
    // regfile writes in the first half-cycle so a WB producer is harmless
    always_comb begin
        if ((ex_regwrite && id_dep_ex_s) || (mem_regwrite && id_dep_mem_s)) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Operands always come from the register file
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
    end

`endif

    // Flush discards the ID word outright, so it never needs to be held
    always_comb begin
        if (id_flush) begin
            stall  = 1'b0;
            bubble = 1'b1;
        end else begin
            stall  = hazard_s;
            bubble = hazard_s;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline ID->EX->MEM->WB with hazard stall and forwarding.
// Carries muxctrl/memctrl/aluctrl plus register fields through the stage
// registers; a bubble (stall or flush) loads an all-zero word into EX.
// Build option HAZ_FWD_EN selects forwarding + load-use stalls; without it
// the pipeline stalls on any EX/MEM producer and never forwards.
module ctrl_pipeline
    import mips_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int MUXW   = DEF_MUXW,
    parameter int MEMW   = DEF_MEMW,
    parameter int ALUW   = DEF_ALUW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MUXW-1:0]   id_muxctrl,
    input  logic [MEMW-1:0]   id_memctrl,
    input  logic [ALUW-1:0]   id_aluctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_flush,
    output logic              stall,
    output logic [MUXW-1:0]   ex_muxctrl,
    output logic [ALUW-1:0]   ex_aluctrl,
    output logic [MEMW-1:0]   mem_memctrl,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // EX stage
    logic [MUXW-1:0]   ex_muxctrl_r;
    logic [MEMW-1:0]   ex_memctrl_r;
    logic [ALUW-1:0]   ex_aluctrl_r;
    logic [REG_AW-1:0] ex_rs_r;
    logic [REG_AW-1:0] ex_rt_r;
    logic              ex_uses_rt_r;
    logic [REG_AW-1:0] ex_dst_r;

    // MEM stage
    logic [MEMW-1:0]   mem_memctrl_r;
    logic              mem_memtoreg_r;
    logic [REG_AW-1:0] mem_dst_r;

    // WB stage
    logic              wb_regwrite_r;
    logic              wb_memtoreg_r;
    logic [REG_AW-1:0] wb_dst_r;

    // Hazard unit results
    logic              stall_s;
    logic              bubble_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_flush     (id_flush),
        .ex_regwrite  (ex_memctrl_r[REGWR]),
        .ex_memread   (ex_memctrl_r[MEMRD]),
        .ex_rs        (ex_rs_r),
        .ex_rt        (ex_rt_r),
        .ex_uses_rt   (ex_uses_rt_r),
        .ex_dst       (ex_dst_r),
        .mem_regwrite (mem_memctrl_r[REGWR]),
        .mem_dst      (mem_dst_r),
        .wb_regwrite  (wb_regwrite_r),
        .wb_dst       (wb_dst_r),
        .stall        (stall_s),
        .bubble       (bubble_s),
        .fwd_a        (fwd_a_s),
        .fwd_b        (fwd_b_s)
    );

    // ID->EX register: take the decoded word, or a zeroed bubble
    always_ff @(posedge clk) begin
        if (reset || bubble_s) begin
            ex_muxctrl_r <= NOOP_MUXCTRL;
            ex_memctrl_r <= NOOP_MEMCTRL;
            ex_aluctrl_r <= NOOP_ALUCTRL;
            ex_rs_r      <= NOOP_REG;
            ex_rt_r      <= NOOP_REG;
            ex_uses_rt_r <= 1'b0;
            ex_dst_r     <= NOOP_REG;
        end else begin
            ex_muxctrl_r <= id_muxctrl;
            ex_memctrl_r <= id_memctrl;
            ex_aluctrl_r <= id_aluctrl;
            ex_rs_r      <= id_rs;
            ex_rt_r      <= id_rt;
            ex_uses_rt_r <= id_uses_rt;
            ex_dst_r     <= id_dst;
        end
    end

    // EX->MEM register: memctrl, the WB data select and the destination
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_memctrl_r  <= NOOP_MEMCTRL;
            mem_memtoreg_r <= 1'b0;
            mem_dst_r      <= NOOP_REG;
        end else begin
            mem_memctrl_r  <= ex_memctrl_r;
            mem_memtoreg_r <= ex_muxctrl_r[MEMTOREG];
            mem_dst_r      <= ex_dst_r;
        end
    end

    // MEM->WB register: only what the register-file write needs
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_regwrite_r <= 1'b0;
            wb_memtoreg_r <= 1'b0;
            wb_dst_r      <= NOOP_REG;
        end else begin
            wb_regwrite_r <= mem_memctrl_r[REGWR];
            wb_memtoreg_r <= mem_memtoreg_r;
            wb_dst_r      <= mem_dst_r;
        end
    end

    assign stall       = stall_s;
    assign fwd_a       = fwd_a_s;
    assign fwd_b       = fwd_b_s;
    assign ex_muxctrl  = ex_muxctrl_r;
    assign ex_aluctrl  = ex_aluctrl_r;
    assign mem_memctrl = mem_memctrl_r;
    assign wb_regwrite = wb_regwrite_r;
    assign wb_memtoreg = wb_memtoreg_r;
    assign wb_dst      = wb_dst_r;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Table-driven bench for ctrl_pipeline. Each table row is one clock cycle:
// ID inputs are applied on the falling edge and all outputs are compared
// 1 time unit later. Expected tables exist for both HAZ_FWD_EN builds.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] id_muxctrl;
    logic [2:0] id_memctrl;
    logic [4:0] id_aluctrl;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_flush;
    logic       stall;
    logic [6:0] ex_muxctrl;
    logic [4:0] ex_aluctrl;
    logic [2:0] mem_memctrl;
    logic       wb_regwrite;
    logic       wb_memtoreg;
    logic [4:0] wb_dst;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    int checks = 0;
    int errors = 0;

    // Instruction encodings used by the vectors
    localparam logic [6:0] MX_A = 7'b0100000;
    localparam logic [6:0] MX_L = 7'b0000011;
    localparam logic [6:0] MX_S = 7'b1000000;
    localparam logic [6:0] MX_B = 7'b0010000;
    localparam logic [6:0] MX_0 = 7'b0000000;
    localparam logic [2:0] MC_W = 3'b001;
    localparam logic [2:0] MC_L = 3'b101;
    localparam logic [2:0] MC_0 = 3'b000;
    localparam logic [4:0] AL_A = 5'd2;
    localparam logic [4:0] AL_L = 5'd1;
    localparam logic [4:0] AL_S = 5'd6;
    localparam logic [4:0] AL_X = 5'd3;
    localparam logic [4:0] AL_Y = 5'd4;
    localparam logic [4:0] AL_0 = 5'd0;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk         (clk),
        .reset       (reset),
        .id_muxctrl  (id_muxctrl),
        .id_memctrl  (id_memctrl),
        .id_aluctrl  (id_aluctrl),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_dst      (id_dst),
        .id_flush    (id_flush),
        .stall       (stall),
        .ex_muxctrl  (ex_muxctrl),
        .ex_aluctrl  (ex_aluctrl),
        .mem_memctrl (mem_memctrl),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .wb_dst      (wb_dst),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    typedef struct {
        logic       rst;
        logic       fl;
        logic [6:0] mux;
        logic [2:0] mem;
        logic [4:0] alu;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic [4:0] dst;
        logic       chk;
        logic       st;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [6:0] exmux;
        logic [4:0] exalu;
        logic [2:0] memmc;
        logic       rw;
        logic       mr;
        logic [4:0] wdst;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic rst, input logic fl, input logic [6:0] mux,
                       input logic [2:0] mem, input logic [4:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic [4:0] dst, input logic chk, input logic st,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [6:0] exmux, input logic [4:0] exalu,
                       input logic [2:0] memmc, input logic rw, input logic mr,
                       input logic [4:0] wdst);
        vec_t v;
        v.rst = rst; v.fl = fl; v.mux = mux; v.mem = mem; v.alu = alu;
        v.rs = rs; v.rt = rt; v.ur = ur; v.dst = dst; v.chk = chk;
        v.st = st; v.fa = fa; v.fb = fb; v.exmux = exmux; v.exalu = exalu;
        v.memmc = memmc; v.rw = rw; v.mr = mr; v.wdst = wdst;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [6:0] mux,
                         input logic [2:0] mem, input logic [4:0] alu,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic [4:0] dst);
        reset      = rst;
        id_flush   = fl;
        id_muxctrl = mux;
        id_memctrl = mem;
        id_aluctrl = alu;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = ur;
        id_dst     = dst;
    endtask

    task automatic check_row(input int idx, input vec_t v);
        logic [26:0] act;
        logic [26:0] exp;
        act = {stall, fwd_a, fwd_b, ex_muxctrl, ex_aluctrl, mem_memctrl,
               wb_regwrite, wb_memtoreg, wb_dst};
        exp = {v.st, v.fa, v.fb, v.exmux, v.exalu, v.memmc, v.rw, v.mr, v.wdst};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row%0d got stall=%b fa=%b fb=%b exmux=%b exalu=%0d memmc=%b wb=%b%b/%0d want stall=%b fa=%b fb=%b exmux=%b exalu=%0d memmc=%b wb=%b%b/%0d",
                     idx, stall, fwd_a, fwd_b, ex_muxctrl, ex_aluctrl, mem_memctrl,
                     wb_regwrite, wb_memtoreg, wb_dst, v.st, v.fa, v.fb, v.exmux,
                     v.exalu, v.memmc, v.rw, v.mr, v.wdst);
        end
    endtask

    // Producer to r20 then a reader of r20 held in ID while stall is high;
    // counts the stall cycles seen by the reader.
    task automatic stall_seq(input logic [6:0] pmux, input logic [2:0] pmem,
                             input int exp_cnt, input string nm);
        int cnt;
        int cyc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, MX_0, MC_0, AL_0, 5'd0, 5'd0, 1'b0, 5'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, pmux, pmem, AL_A, 5'd1, 5'd2, 1'b0, 5'd20);
        @(negedge clk);
        drive(1'b0, 1'b0, MX_S, MC_W, AL_S, 5'd20, 5'd0, 1'b0, 5'd21);
        #1;
        cnt = 0;
        cyc = 0;
        while (stall === 1'b1 && cyc < 8) begin
            cnt++;
            cyc++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (cyc >= 8) begin
            errors++;
            $display("FAIL %s stall did not release within 8 cycles", nm);
        end else if (cnt != exp_cnt) begin
            errors++;
            $display("FAIL %s stall cycles got %0d want %0d", nm, cnt, exp_cnt);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, MX_A, MC_W, AL_A, 5'd1, 5'd2, 1'b1, 5'd7);

        // rst fl mux  mem  alu  rs  rt  ur  dst | chk st fa fb exmux exalu memmc rw mr wdst
        row(1, 0, MX_A, MC_W, AL_A, 1, 2, 1, 7,   1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(1, 0, MX_A, MC_W, AL_A, 1, 2, 1, 7,   1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(0, 0, MX_0, MC_0, AL_0, 0, 0, 0, 0,   1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
`ifdef HAZ_FWD_EN
        row(0, 0, MX_L, MC_L, AL_L, 1, 0, 0, 8,   1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(0, 0, MX_A, MC_W, AL_A, 8, 1, 1, 9,   1, 1, 0, 0, MX_L, AL_L, MC_0, 0, 0, 0);
        row(0, 0, MX_A, MC_W, AL_A, 8, 1, 1, 9,   1, 0, 0, 0, MX_0, AL_0, MC_L, 0, 0, 0);
        row(0, 0, MX_A, MC_W, AL_A, 2, 2, 1, 3,   1, 0, 1, 0, MX_A, AL_A, MC_0, 1, 1, 8);
        row(0, 0, MX_S, MC_W, AL_S, 3, 3, 1, 10,  1, 0, 0, 0, MX_A, AL_A, MC_W, 0, 0, 0);
        row(0, 0, MX_A, MC_W, AL_A, 1, 1, 0, 5,   1, 0, 2, 2, MX_S, AL_S, MC_W, 1, 0, 9);
        row(0, 0, MX_A, MC_W, AL_X, 1, 1, 0, 5,   1, 0, 0, 0, MX_A, AL_A, MC_W, 1, 0, 3);
        row(0, 0, MX_S, MC_W, AL_S, 5, 5, 0, 6,   1, 0, 0, 0, MX_A, AL_X, MC_W, 1, 0, 10);
        row(0, 0, MX_L, MC_L, AL_L, 2, 0, 0, 4,   1, 0, 2, 0, MX_S, AL_S, MC_W, 1, 0, 5);
        row(0, 1, MX_S, MC_W, AL_S, 4, 0, 0, 7,   1, 0, 0, 0, MX_L, AL_L, MC_W, 1, 0, 5);
        row(0, 0, MX_A, MC_W, AL_A, 1, 0, 0, 0,   1, 0, 0, 0, MX_0, AL_0, MC_L, 1, 0, 6);
        row(0, 0, MX_S, MC_W, AL_S, 0, 0, 1, 11,  1, 0, 0, 0, MX_A, AL_A, MC_0, 1, 1, 4);
        row(0, 0, MX_0, MC_0, AL_0, 0, 0, 0, 0,   1, 0, 0, 0, MX_S, AL_S, MC_W, 0, 0, 0);
        row(0, 0, MX_L, MC_L, AL_L, 1, 0, 0, 12,  1, 0, 0, 0, MX_0, AL_0, MC_W, 1, 0, 0);
        row(0, 0, MX_S, MC_W, AL_S, 3, 12, 1, 13, 1, 1, 0, 0, MX_L, AL_L, MC_0, 1, 0, 11);
        row(1, 0, MX_S, MC_W, AL_S, 3, 12, 1, 13, 0, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(0, 0, MX_0, MC_0, AL_0, 0, 0, 0, 0,   1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
`else
        row(0, 0, MX_A, MC_W, AL_A, 1, 2, 1, 7,   1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(0, 0, MX_S, MC_W, AL_S, 7, 3, 1, 9,   1, 1, 0, 0, MX_A, AL_A, MC_0, 0, 0, 0);
        row(0, 0, MX_S, MC_W, AL_S, 7, 3, 1, 9,   1, 1, 0, 0, MX_0, AL_0, MC_W, 0, 0, 0);
        row(0, 0, MX_S, MC_W, AL_S, 7, 3, 1, 9,   1, 0, 0, 0, MX_0, AL_0, MC_0, 1, 0, 7);
        row(0, 0, MX_L, MC_L, AL_L, 2, 0, 0, 4,   1, 0, 0, 0, MX_S, AL_S, MC_0, 0, 0, 0);
        row(0, 1, MX_S, MC_W, AL_S, 4, 0, 0, 10,  1, 0, 0, 0, MX_L, AL_L, MC_W, 0, 0, 0);
        row(0, 0, MX_A, MC_W, AL_A, 1, 0, 0, 0,   1, 0, 0, 0, MX_0, AL_0, MC_L, 1, 0, 9);
        row(0, 0, MX_S, MC_W, AL_S, 0, 0, 1, 11,  1, 0, 0, 0, MX_A, AL_A, MC_0, 1, 1, 4);
        row(0, 0, MX_B, MC_0, AL_X, 5, 11, 0, 0,  1, 0, 0, 0, MX_S, AL_S, MC_W, 0, 0, 0);
        row(0, 0, MX_0, MC_W, AL_Y, 1, 11, 1, 12, 1, 1, 0, 0, MX_B, AL_X, MC_W, 1, 0, 0);
        row(0, 0, MX_0, MC_W, AL_Y, 1, 11, 1, 12, 1, 0, 0, 0, MX_0, AL_0, MC_0, 1, 0, 11);
        row(0, 0, MX_0, MC_0, AL_0, 0, 0, 0, 0,   1, 0, 0, 0, MX_0, AL_Y, MC_0, 0, 0, 0);
        row(0, 0, MX_A, MC_W, AL_A, 1, 2, 1, 13,  1, 0, 0, 0, MX_0, AL_0, MC_W, 0, 0, 0);
        row(0, 0, MX_S, MC_W, AL_S, 13, 0, 0, 14, 1, 1, 0, 0, MX_A, AL_A, MC_0, 1, 0, 12);
        row(1, 0, MX_S, MC_W, AL_S, 13, 0, 0, 14, 0, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(0, 0, MX_S, MC_W, AL_S, 13, 0, 0, 14, 1, 0, 0, 0, MX_0, AL_0, MC_0, 0, 0, 0);
        row(0, 0, MX_0, MC_0, AL_0, 0, 0, 0, 0,   1, 0, 0, 0, MX_S, AL_S, MC_0, 0, 0, 0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].fl, tbl[i].mux, tbl[i].mem, tbl[i].alu,
                  tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].dst);
            #1;
            if (tbl[i].chk) begin
                check_row(i, tbl[i]);
            end
        end

`ifdef HAZ_FWD_EN
        stall_seq(MX_A, MC_W, 0, "alu_dep");
        stall_seq(MX_L, MC_L, 1, "load_dep");
        stall_seq(MX_0, 3'b010, 0, "store_dep");
`else
        stall_seq(MX_A, MC_W, 2, "alu_dep");
        stall_seq(MX_L, MC_L, 2, "load_dep");
        stall_seq(MX_0, 3'b010, 0, "store_dep");
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, MX_0, MC_0, AL_0, 5'd0, 5'd0, 1'b0, 5'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
